// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Brief    : Operand forwarding, 16-bit ALU, CCR, branch resolution and the
//            interrupt PC-push sequencer, with a registered E/M output stage.
// Revision : 1.0
// ============================================================================
module execute_stage #(
    parameter int              DATA_W     = 16,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] INT_VECTOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [13:0]       ctrl_in,
    input  logic [DATA_W-1:0] rdata1_in,
    input  logic [DATA_W-1:0] rdata2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [2:0]        wadd1_in,
    input  logic [2:0]        wadd2_in,
    input  logic [3:0]        func_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              int_in,
    input  logic [2:0]        rsrc1_in,
    input  logic [2:0]        rsrc2_in,
    input  logic              fwd_em_we,
    input  logic              fwd_mw_we,
    input  logic [2:0]        fwd_em_addr,
    input  logic [2:0]        fwd_mw_addr,
    input  logic [DATA_W-1:0] fwd_em_data,
    input  logic [DATA_W-1:0] fwd_mw_data,
    input  logic              stall,
    input  logic              flush,
    output logic [13:0]       ctrl_out,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] store_out,
    output logic [2:0]        wadd1_out,
    output logic [2:0]        wadd2_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [2:0]        ccr_out,
    output logic              br_taken,
    output logic [PC_W-1:0]   br_target,
    output logic              int_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PUSH_HI = 2'd1,
        S_PUSH_LO = 2'd2
    } state_t;

    localparam int          C_ALUSRC    = 1;
    localparam int          C_BRANCH    = 9;
    localparam int          C_SETC      = 11;
    localparam int          C_CLRC      = 12;
    localparam int          C_RTI       = 13;
    localparam logic [13:0] C_PUSH_WORD = 14'h0020;

    state_t            state_q, state_d;
    logic [13:0]       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] result_q, result_d, store_q, store_d;
    logic [2:0]        wadd1_q, wadd1_d, wadd2_q, wadd2_d;
    logic [PC_W-1:0]   pc_q, pc_d, ipc_q, ipc_d, tgt_q, tgt_d;
    logic              brt_q, brt_d;
    logic [2:0]        ccr_q, ccr_d, shadow_q, shadow_d;

    logic [DATA_W-1:0] op_a, op_b_reg, op_b, alu_res, pc_inc;
    logic [DATA_W:0]   ext;
    logic [3:0]        shamt;
    logic              carry_wr, carry_val, zn_wr;
    logic              is_branch, is_call, cond, taken, advance;
    logic [2:0]        ccr_new;

    // EM stage is younger than MW, so its result wins on a double match
    assign op_a = (fwd_em_we && fwd_em_addr == rsrc1_in) ? fwd_em_data :
                  (fwd_mw_we && fwd_mw_addr == rsrc1_in) ? fwd_mw_data : rdata1_in;
    assign op_b_reg = (fwd_em_we && fwd_em_addr == rsrc2_in) ? fwd_em_data :
                      (fwd_mw_we && fwd_mw_addr == rsrc2_in) ? fwd_mw_data : rdata2_in;
    assign op_b      = ctrl_in[C_ALUSRC] ? imm_in : op_b_reg;
    assign shamt     = op_b[3:0];
    assign pc_inc    = pc_in[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, 1'b1};
    assign zn_wr     = (func_in >= 4'd1) && (func_in <= 4'd10);
    assign is_branch = ctrl_in[C_BRANCH] && (func_in >= 4'd11);
    assign is_call   = is_branch && (func_in == 4'd15);
    assign taken     = is_branch && cond;
    assign advance   = flush || !stall;

    always_comb begin
        alu_res   = op_a;
        ext       = '0;
        carry_wr  = 1'b0;
        carry_val = 1'b0;
        case (func_in)
            4'd1: alu_res = ~op_a;
            4'd2: begin
                ext       = {1'b0, op_a} + {{DATA_W{1'b0}}, 1'b1};
                alu_res   = ext[DATA_W-1:0];
                carry_wr  = 1'b1;
                carry_val = ext[DATA_W];
            end
            4'd3: begin
                ext       = {1'b0, op_a} - {{DATA_W{1'b0}}, 1'b1};
                alu_res   = ext[DATA_W-1:0];
                carry_wr  = 1'b1;
                carry_val = ext[DATA_W];
            end
            4'd4: begin
                ext       = {1'b0, op_a} + {1'b0, op_b};
                alu_res   = ext[DATA_W-1:0];
                carry_wr  = 1'b1;
                carry_val = ext[DATA_W];
            end
            4'd5: begin
                ext       = {1'b0, op_a} - {1'b0, op_b};
                alu_res   = ext[DATA_W-1:0];
                carry_wr  = 1'b1;
                carry_val = ext[DATA_W];
            end
            4'd6: alu_res = op_a & op_b;
            4'd7: alu_res = op_a | op_b;
            // Extra guard bit catches the last bit shifted out on either side
            4'd8: begin
                ext       = {1'b0, op_a} << shamt;
                alu_res   = ext[DATA_W-1:0];
                carry_wr  = |shamt;
                carry_val = ext[DATA_W];
            end
            4'd9: begin
                ext       = {op_a, 1'b0} >> shamt;
                alu_res   = ext[DATA_W:1];
                carry_wr  = |shamt;
                carry_val = ext[0];
            end
            4'd10:   alu_res = op_b;
            default: alu_res = op_a;
        endcase
    end

    always_comb begin
        case (func_in)
            4'd11:   cond = ccr_q[0];
            4'd12:   cond = ccr_q[1];
            4'd13:   cond = ccr_q[2];
            default: cond = 1'b1;
        endcase
    end

    always_comb begin
        ccr_new = ccr_q;
        if (carry_wr) ccr_new[2] = carry_val;
        if (zn_wr) begin
            ccr_new[0] = ~|alu_res;
            ccr_new[1] = alu_res[DATA_W-1];
        end
        if (ctrl_in[C_SETC]) ccr_new[2] = 1'b1;
        if (ctrl_in[C_CLRC]) ccr_new[2] = 1'b0;
        if (taken) begin
            case (func_in)
                4'd11:   ccr_new[0] = 1'b0;
                4'd12:   ccr_new[1] = 1'b0;
                4'd13:   ccr_new[2] = 1'b0;
                default: ccr_new    = ccr_new;
            endcase
        end
        if (ctrl_in[C_RTI]) ccr_new = shadow_q;
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        store_d  = store_q;
        wadd1_d  = wadd1_q;
        wadd2_d  = wadd2_q;
        pc_d     = pc_q;
        ipc_d    = ipc_q;
        tgt_d    = tgt_q;
        brt_d    = brt_q;
        ccr_d    = ccr_q;
        shadow_d = shadow_q;
        if (advance) begin
            case (state_q)
                S_IDLE: begin
                    ctrl_d   = flush ? '0 : ctrl_in;
                    result_d = is_call ? pc_inc : alu_res;
                    store_d  = op_b_reg;
                    wadd1_d  = wadd1_in;
                    wadd2_d  = wadd2_in;
                    pc_d     = pc_in;
                    brt_d    = taken && !flush;
                    tgt_d    = {{(PC_W-DATA_W){1'b0}}, op_a};
                    if (!flush) begin
                        ccr_d = ccr_new;
                        // Shadow holds the flags as left by the interrupted instruction
                        if (int_in) begin
                            state_d  = S_PUSH_HI;
                            shadow_d = ccr_new;
                            ipc_d    = pc_in;
                        end
                    end
                end
                S_PUSH_HI: begin
                    ctrl_d   = C_PUSH_WORD;
                    result_d = ipc_q[PC_W-1 -: DATA_W];
                    store_d  = ipc_q[PC_W-1 -: DATA_W];
                    wadd1_d  = '0;
                    wadd2_d  = '0;
                    pc_d     = ipc_q;
                    brt_d    = 1'b0;
                    state_d  = S_PUSH_LO;
                end
                default: begin
                    ctrl_d   = C_PUSH_WORD;
                    result_d = ipc_q[DATA_W-1:0];
                    store_d  = ipc_q[DATA_W-1:0];
                    wadd1_d  = '0;
                    wadd2_d  = '0;
                    pc_d     = ipc_q;
                    brt_d    = 1'b1;
                    tgt_d    = INT_VECTOR;
                    state_d  = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            result_q <= '0;
            store_q  <= '0;
            wadd1_q  <= '0;
            wadd2_q  <= '0;
            pc_q     <= '0;
            ipc_q    <= '0;
            tgt_q    <= '0;
            brt_q    <= 1'b0;
            ccr_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            store_q  <= store_d;
            wadd1_q  <= wadd1_d;
            wadd2_q  <= wadd2_d;
            pc_q     <= pc_d;
            ipc_q    <= ipc_d;
            tgt_q    <= tgt_d;
            brt_q    <= brt_d;
            ccr_q    <= ccr_d;
            shadow_q <= shadow_d;
        end
    end

    assign ctrl_out   = ctrl_q;
    assign result_out = result_q;
    assign store_out  = store_q;
    assign wadd1_out  = wadd1_q;
    assign wadd2_out  = wadd2_q;
    assign pc_out     = pc_q;
    assign ccr_out    = ccr_q;
    assign br_taken   = brt_q;
    assign br_target  = tgt_q;
    assign int_busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Brief    : Self-checking bench for execute_stage: directed scenarios plus
//            random traffic against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_execute_stage;

    localparam logic [31:0] TB_VEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] ctrl_in;
    logic [15:0] rdata1_in, rdata2_in, imm_in;
    logic [2:0]  wadd1_in, wadd2_in, rsrc1_in, rsrc2_in;
    logic [3:0]  func_in;
    logic [31:0] pc_in;
    logic        int_in, fwd_em_we, fwd_mw_we, stall, flush;
    logic [2:0]  fwd_em_addr, fwd_mw_addr;
    logic [15:0] fwd_em_data, fwd_mw_data;
    logic [13:0] ctrl_out;
    logic [15:0] result_out, store_out;
    logic [2:0]  wadd1_out, wadd2_out, ccr_out;
    logic [31:0] pc_out, br_target;
    logic        br_taken, int_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state and expected outputs
    logic [2:0]  m_ccr, m_shadow;
    int          m_phase;
    logic [31:0] m_ipc;
    logic [13:0] e_ctrl;
    logic [15:0] e_res, e_store;
    logic [2:0]  e_w1, e_w2;
    logic [31:0] e_pc, e_tgt;
    logic        e_brt, k_res, k_data;

    execute_stage #(.DATA_W(16), .PC_W(32), .INT_VECTOR(TB_VEC)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in),
        .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
        .wadd1_in(wadd1_in), .wadd2_in(wadd2_in), .func_in(func_in),
        .pc_in(pc_in), .int_in(int_in), .rsrc1_in(rsrc1_in), .rsrc2_in(rsrc2_in),
        .fwd_em_we(fwd_em_we), .fwd_mw_we(fwd_mw_we),
        .fwd_em_addr(fwd_em_addr), .fwd_mw_addr(fwd_mw_addr),
        .fwd_em_data(fwd_em_data), .fwd_mw_data(fwd_mw_data),
        .stall(stall), .flush(flush), .ctrl_out(ctrl_out),
        .result_out(result_out), .store_out(store_out),
        .wadd1_out(wadd1_out), .wadd2_out(wadd2_out), .pc_out(pc_out),
        .ccr_out(ccr_out), .br_taken(br_taken), .br_target(br_target),
        .int_busy(int_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] fwd(input logic [2:0] src, input logic [15:0] rf,
                                         input logic emwe, input logic [2:0] ema, input logic [15:0] emd,
                                         input logic mwwe, input logic [2:0] mwa, input logic [15:0] mwd);
        if (emwe && ema == src) return emd;
        if (mwwe && mwa == src) return mwd;
        return rf;
    endfunction

    task automatic model_reset();
        m_ccr = '0; m_shadow = '0; m_phase = 0; m_ipc = '0;
        e_ctrl = '0; e_res = '0; e_store = '0; e_w1 = '0; e_w2 = '0;
        e_pc = '0; e_tgt = '0; e_brt = 1'b0; k_res = 1'b1; k_data = 1'b1;
    endtask

    task automatic nop();
        ctrl_in = '0; rdata1_in = '0; rdata2_in = '0; imm_in = '0;
        wadd1_in = '0; wadd2_in = '0; func_in = '0; pc_in = '0; int_in = 1'b0;
        rsrc1_in = 3'd1; rsrc2_in = 3'd2; fwd_em_we = 1'b0; fwd_mw_we = 1'b0;
        fwd_em_addr = '0; fwd_mw_addr = '0; fwd_em_data = '0; fwd_mw_data = '0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic compare_all();
        check("ctrl_out", 32'(ctrl_out), 32'(e_ctrl));
        check("br_taken", 32'(br_taken), 32'(e_brt));
        check("ccr_out", 32'(ccr_out), 32'(m_ccr));
        check("int_busy", 32'(int_busy), 32'(m_phase != 0));
        if (e_brt) check("br_target", br_target, e_tgt);
        if (k_res) check("result_out", 32'(result_out), 32'(e_res));
        if (k_data) begin
            check("store_out", 32'(store_out), 32'(e_store));
            check("wadd1_out", 32'(wadd1_out), 32'(e_w1));
            check("wadd2_out", 32'(wadd2_out), 32'(e_w2));
            check("pc_out", pc_out, e_pc);
        end
    endtask

    // Predict from the current inputs, clock once, then compare
    task automatic step();
        logic [15:0] a, breg, b, r;
        logic [2:0]  nc;
        logic        tk;
        int          ai, bi, ri, s;
        if (!stall || flush) begin
            if (m_phase == 0) begin
                a    = fwd(rsrc1_in, rdata1_in, fwd_em_we, fwd_em_addr, fwd_em_data,
                           fwd_mw_we, fwd_mw_addr, fwd_mw_data);
                breg = fwd(rsrc2_in, rdata2_in, fwd_em_we, fwd_em_addr, fwd_em_data,
                           fwd_mw_we, fwd_mw_addr, fwd_mw_data);
                b    = ctrl_in[1] ? imm_in : breg;
                ai = int'(a); bi = int'(b); s = int'(b[3:0]); ri = ai; nc = m_ccr;
                case (func_in)
                    4'd1:  ri = 65535 - ai;
                    4'd2:  begin ri = ai + 1;  nc[2] = (ri > 65535); end
                    4'd3:  begin ri = ai - 1;  nc[2] = (ai < 1);     end
                    4'd4:  begin ri = ai + bi; nc[2] = (ri > 65535); end
                    4'd5:  begin ri = ai - bi; nc[2] = (ai < bi);    end
                    4'd6:  ri = ai & bi;
                    4'd7:  ri = ai | bi;
                    4'd8:  begin ri = ai << s; if (s != 0) nc[2] = ((ai >> (16 - s)) & 1) != 0; end
                    4'd9:  begin ri = ai >> s; if (s != 0) nc[2] = ((ai >> (s - 1)) & 1) != 0; end
                    4'd10: ri = bi;
                    default: ri = ai;
                endcase
                r = ri[15:0];
                if (func_in >= 4'd1 && func_in <= 4'd10) begin
                    nc[0] = (r == 16'h0);
                    nc[1] = r[15];
                end
                if (ctrl_in[11]) nc[2] = 1'b1;
                if (ctrl_in[12]) nc[2] = 1'b0;
                tk = 1'b0;
                if (ctrl_in[9] && func_in >= 4'd11) begin
                    case (func_in)
                        4'd11:   if (m_ccr[0]) begin tk = 1'b1; nc[0] = 1'b0; end
                        4'd12:   if (m_ccr[1]) begin tk = 1'b1; nc[1] = 1'b0; end
                        4'd13:   if (m_ccr[2]) begin tk = 1'b1; nc[2] = 1'b0; end
                        default: tk = 1'b1;
                    endcase
                end
                if (ctrl_in[13]) nc = m_shadow;
                e_ctrl  = flush ? 14'h0 : ctrl_in;
                e_res   = (ctrl_in[9] && func_in == 4'd15) ? (pc_in[15:0] + 16'd1) : r;
                k_res   = !flush && !(ctrl_in[9] && func_in >= 4'd11 && func_in <= 4'd14);
                e_store = breg; e_w1 = wadd1_in; e_w2 = wadd2_in; e_pc = pc_in;
                k_data  = !flush;
                e_brt   = tk && !flush;
                e_tgt   = {16'h0, a};
                if (!flush) begin
                    m_ccr = nc;
                    if (int_in) begin
                        m_phase = 1; m_shadow = nc; m_ipc = pc_in;
                    end
                end
            end else if (m_phase == 1) begin
                e_ctrl = 14'h0020; e_res = m_ipc[31:16]; k_res = 1'b1; k_data = 1'b0;
                e_brt = 1'b0; m_phase = 2;
            end else begin
                e_ctrl = 14'h0020; e_res = m_ipc[15:0]; k_res = 1'b1; k_data = 1'b0;
                e_brt = 1'b1; e_tgt = TB_VEC; m_phase = 0;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        nop();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // ADD FFFF + 0001 -> 0000, C=1 N=0 Z=1
        nop(); ctrl_in[0] = 1'b1; rdata1_in = 16'hFFFF; rdata2_in = 16'h0001; func_in = 4'd4;
        step();
        check("add_result", 32'(result_out), 32'h0);
        check("add_ccr", 32'(ccr_out), 32'h5);

        // forwarding priority
        nop(); rsrc1_in = 3'd3; func_in = 4'd0;
        fwd_em_we = 1'b1; fwd_em_addr = 3'd3; fwd_em_data = 16'h1234;
        fwd_mw_we = 1'b1; fwd_mw_addr = 3'd3; fwd_mw_data = 16'h5678;
        step();
        check("fwd_em", 32'(result_out), 32'h1234);
        fwd_em_we = 1'b0;
        step();
        check("fwd_mw", 32'(result_out), 32'h5678);

        // JZ taken with Z=1, then not taken with Z=0
        nop(); ctrl_in[9] = 1'b1; func_in = 4'd11; rdata1_in = 16'h0040;
        step();
        check("jz_taken", 32'(br_taken), 32'h1);
        check("jz_target", br_target, 32'h40);
        check("jz_zclr", 32'(ccr_out[0]), 32'h0);
        nop();
        step();
        check("jz_pulse", 32'(br_taken), 32'h0);
        ctrl_in[9] = 1'b1; func_in = 4'd11; rdata1_in = 16'h0040;
        step();
        check("jz_nottaken", 32'(br_taken), 32'h0);

        // SUB 0-1 sets C,N; then interrupt at 0x00012345
        nop(); rdata1_in = 16'h0; rdata2_in = 16'h1; func_in = 4'd5;
        step();
        check("sub_ccr", 32'(ccr_out), 32'h6);
        nop(); int_in = 1'b1; pc_in = 32'h0001_2345;
        step();
        check("int_busy1", 32'(int_busy), 32'h1);
        nop(); int_in = 1'b1;
        step();
        check("push_hi", 32'(result_out), 32'h0001);
        check("int_busy2", 32'(int_busy), 32'h1);
        nop();
        step();
        check("push_lo", 32'(result_out), 32'h2345);
        check("int_vec", br_target, TB_VEC);
        check("int_done", 32'(int_busy), 32'h0);
        nop(); func_in = 4'd4;
        step();
        check("ccr_clobber", 32'(ccr_out), 32'h1);
        nop(); ctrl_in[13] = 1'b1;
        step();
        check("rti_restore", 32'(ccr_out), 32'h6);

        // flush beats stall; CCR untouched, data still moves
        nop(); ctrl_in[0] = 1'b1; func_in = 4'd4; pc_in = 32'h77; flush = 1'b1; stall = 1'b1;
        step();
        check("flush_ctrl", 32'(ctrl_out), 32'h0);
        check("flush_ccr", 32'(ccr_out), 32'h6);
        check("flush_pc", pc_out, 32'h77);

        // stall alone holds outputs
        nop(); ctrl_in = 14'h0003; func_in = 4'd2; pc_in = 32'h99; stall = 1'b1;
        step();
        check("stall_pc", pc_out, 32'h77);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            ctrl_in     = 14'($urandom);
            ctrl_in[13] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) begin
                ctrl_in[9] = 1'b1;
                func_in    = 4'(11 + $urandom_range(0, 4));
            end else begin
                ctrl_in[9] = 1'b0;
                func_in    = 4'($urandom_range(0, 10));
            end
            rdata1_in   = 16'($urandom); rdata2_in = 16'($urandom); imm_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rdata1_in = 16'h0;
            wadd1_in    = 3'($urandom); wadd2_in = 3'($urandom);
            rsrc1_in    = 3'($urandom); rsrc2_in = 3'($urandom);
            fwd_em_we   = 1'($urandom); fwd_mw_we = 1'($urandom);
            fwd_em_addr = 3'($urandom); fwd_mw_addr = 3'($urandom);
            fwd_em_data = 16'($urandom); fwd_mw_data = 16'($urandom);
            pc_in       = $urandom;
            int_in      = ($urandom_range(0, 19) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            stall       = ($urandom_range(0, 7) == 0);
            step();
        end

        // drain, then reset in the middle of PUSH_HI
        nop();
        repeat (3) step();
        nop(); int_in = 1'b1; pc_in = 32'hABCD_1234;
        step();
        check("rst_pre_busy", 32'(int_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(int_busy), 32'h0);
        check("rst_ctrl", 32'(ctrl_out), 32'h0);
        check("rst_result", 32'(result_out), 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_ccr", 32'(ccr_out), 32'h0);
        check("rst_brt", 32'(br_taken), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        nop();
        step();
        check("post_rst_busy", 32'(int_busy), 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage directly downstream of the decode/execute pipeline register; consumes its control word, operands, write addresses, function code, PC and interrupt flag.
- Performs operand forwarding, 16-bit ALU, condition-code register (CCR: Z,N,C) update and branch resolution.
- Runs a 3-state interrupt sequencer.
- Outputs are registered (built-in E/M register) and feed the memory stage.

Parameters:
- DATA_W, 16, operand/result width
- PC_W, 32, program-counter width
- INT_VECTOR, 32'h0000_0000, PC loaded on interrupt entry

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ctrl_in  in  14  [0]RegWr [1]ALUsrc [2]MemRd [3]MemWr [4]MemtoReg [5]Push [6]Pop [7]Out [8]In [9]Branch [10]Swap [11]SetC [12]ClrC [13]RTI
- rdata1_in, rdata2_in  in  16  operands A, B
- imm_in  in  16  immediate; replaces B when ALUsrc=1
- wadd1_in, wadd2_in  in  3  destination registers (wadd2 used only by Swap)
- func_in  in  4  ALU/branch function code
- pc_in  in  32  instruction PC
- int_in  in  1  interrupt flag from D/E register
- rsrc1_in, rsrc2_in  in  3  source register numbers of A, B
- fwd_em_we, fwd_mw_we  in  1  downstream write enables
- fwd_em_addr, fwd_mw_addr  in  3  downstream destinations
- fwd_em_data, fwd_mw_data  in  16  downstream results
- stall  in  1  hold all state and outputs
- flush  in  1  kill the current instruction
- ctrl_out  out  14  registered control word
- result_out  out  16  registered ALU result
- store_out  out  16  registered forwarded B (store/swap data)
- wadd1_out, wadd2_out  out  3  registered destinations
- pc_out  out  32  registered PC
- ccr_out  out  3  {C,N,Z} live CCR
- br_taken  out  1  registered; asserted 1 cycle
- br_target  out  32  registered target
- int_busy  out  1  sequencer not in IDLE; upstream must stall

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; CCR=0; shadow CCR=0; sequencer=IDLE.
  - Deassertion is sampled synchronously.
- Latency: 1 cycle, input to registered output.
- Forwarding, per operand:
  - Use fwd_em_data if fwd_em_we=1 and fwd_em_addr=rsrc.
  - Otherwise use fwd_mw_data if fwd_mw_we=1 and fwd_mw_addr=rsrc.
  - Otherwise use rdata. EM has priority.
- B select: B = imm_in when ALUsrc=1, otherwise forwarded rdata2.
- ALU functions:
  - 0 PASS A, 1 NOT A, 2 A+1, 3 A-1, 4 A+B, 5 A-B, 6 A&B, 7 A|B, 8 A<<B[3:0], 9 A>>B[3:0] (logical), 10 PASS B.
  - 11 JZ, 12 JN, 13 JC, 14 JMP, 15 CALL.
- Arithmetic and flags:
  - Arithmetic uses a 17-bit result; bit16 goes to C on 2-5. Subtraction sets C = borrow.
  - Shifts set C to the last bit shifted out; shift by 0 leaves C unchanged.
  - Z and N update on functions 1-10 only.
  - SetC/ClrC force C; if both are set, ClrC wins.
- Branches (Branch=1, func 11-15):
  - Condition: JZ→Z, JN→N, JC→C, JMP/CALL→1. Target = zero-extended forwarded A.
  - Taken JZ/JN/JC clears the tested flag.
  - Taken: br_taken=1 next cycle.
  - CALL additionally passes pc_in+1 in result_out.
- Flush:
  - ctrl_out, br_taken and int are zeroed at the next edge; CCR is not updated.
  - Data outputs take new values but are don't-care.
- Stall: all registers and CCR hold; flush has priority over stall.
- Sequencer, states IDLE, PUSH_HI, PUSH_LO:
  - IDLE→PUSH_HI when int_in=1 and not flush. Current instruction completes normally; shadow←CCR.
  - PUSH_HI: emit Push with result_out=pc_in[31:16] (latched PC); →PUSH_LO.
  - PUSH_LO: emit Push with result_out=pc[15:0]; br_taken=1, br_target=INT_VECTOR; →IDLE.
  - int_busy=1 in PUSH_HI/PUSH_LO; input instructions are ignored.
  - int_in during PUSH_* is ignored.
  - RTI (ctrl[13]) restores CCR←shadow at its execute edge.
- rst_n low mid-sequence: immediate return to IDLE, outputs cleared, no partial push completes.

Test Plan:
- Reset, then ADD A=16'hFFFF B=16'h0001, func 4 → next cycle result_out=0000, ccr={C1,N0,Z1}.
- EM and MW both write r3; fwd_em_data=0x1234, fwd_mw_data=0x5678; rsrc1=3, PASS A → result_out=0x1234. Drop fwd_em_we → 0x5678.
- JZ with Z=1, A=0x0040 → br_taken=1 for 1 cycle, br_target=0x00000040, Z→0. Repeat with Z=0 → br_taken=0.
- Interrupt at pc_in=0x00012345 → int_busy 2 cycles; pushes 0x0001 then 0x2345; br_target=INT_VECTOR. RTI later → CCR restored to the pre-interrupt value.
- flush together with ADD that sets Z, plus stall=1 → ctrl_out=0, CCR unchanged, outputs update (flush beats stall).
- Assert rst_n=0 during PUSH_HI → all outputs 0 asynchronously, state IDLE, int_busy=0.
